// File: rtl/clk_logic_pipe_pkg.sv
// Shared types and the operation table for the pipelined bitwise logic unit.
// Latency: none; package contents are purely combinational helpers.
// Backpressure: not applicable.
package clk_logic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND     = 3'd0,
        OP_OR      = 3'd1,
        OP_XOR     = 3'd2,
        OP_NAND    = 3'd3,
        OP_NOR     = 3'd4,
        OP_XNOR    = 3'd5,
        OP_ACC_XOR = 3'd6,
        OP_ACC_OR  = 3'd7
    } op_t;

    // Result of one beat at the widest supported width; callers truncate.
    // For the accumulating ops, acc is the accumulator value after any
    // clear, so the return value is also the new accumulator contents.
    function automatic logic [31:0] apply_op(input op_t         op,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] acc);
        logic [31:0] r;
        case (op)
            OP_AND:     r = a & b;
            OP_OR:      r = a | b;
            OP_XOR:     r = a ^ b;
            OP_NAND:    r = ~(a & b);
            OP_NOR:     r = ~(a | b);
            OP_XNOR:    r = ~(a ^ b);
            OP_ACC_XOR: r = acc ^ (a & b);
            OP_ACC_OR:  r = acc | (a & b);
            default:    r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic is_acc_op(input op_t op);
        return (op == OP_ACC_XOR) || (op == OP_ACC_OR);
    endfunction

endpackage

// File: rtl/clk_logic_pipe_if.sv
// Bundles the input beat, output result and both handshakes of the logic unit.
// Latency: none; wiring only.
// Backpressure: in_ready/out_ready carry the valid/ready flow control.
interface clk_logic_pipe_if #(
    parameter int WIDTH = 8
) ();
    import clk_logic_pkg::*;

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;

    // Producer/consumer side (the environment around the unit).
    modport master (
        output in_valid, op, a, b, acc_clr, out_ready,
        input  in_ready, out_valid, y
    );

    // The logic unit itself.
    modport slave (
        input  in_valid, op, a, b, acc_clr, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/clk_logic_stage.sv
// One elastic register stage: holds a single {valid, data} beat.
// Latency: 1 cycle from in_vld_i/in_dat_i to out_vld_o/out_dat_o.
// Backpressure: accepts when empty or when downstream takes the held beat.
module clk_logic_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld_i,
    input  logic [WIDTH-1:0] in_dat_i,
    output logic             in_rdy_o,
    output logic             out_vld_o,
    output logic [WIDTH-1:0] out_dat_o,
    input  logic             out_rdy_i
);
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    // An empty stage never blocks, so bubbles collapse under stall.
    assign in_rdy_o  = !vld_q || out_rdy_i;
    assign out_vld_o = vld_q;
    assign out_dat_o = dat_q;

    // Load the upstream beat (or a bubble) whenever this stage can move.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (in_rdy_o) begin
            vld_d = in_vld_i;
            if (in_vld_i) begin
                dat_d = in_dat_i;
            end
        end
    end

    // Stage register; reset discards any in-flight beat and zeroes the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end
endmodule

// File: rtl/clk_logic_pipe.sv
// Pipelined bitwise logic unit with eight ops, including two running accumulators.
// Latency: STAGES cycles from acceptance to y (y valid after edge t+STAGES-1).
// Backpressure: full valid/ready; stalls hold y stable, no beat lost or duplicated.
module clk_logic_pipe
    import clk_logic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    clk_logic_pipe_if.slave bus
);
    logic             in_rdy;
    logic             accept;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] res;

    // The result is formed at acceptance, so stage 0 holds finished data and
    // y is purely registered.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_vld;
        logic [WIDTH-1:0] up_dat;
        logic             dn_rdy;
        logic             rdy;
        logic             vld;
        logic [WIDTH-1:0] dat;

        if (i == 0) begin : g_first
            assign up_vld = bus.in_valid;
            assign up_dat = res;
        end else begin : g_next
            assign up_vld = g_stage[i-1].vld;
            assign up_dat = g_stage[i-1].dat;
        end

        if (i == STAGES - 1) begin : g_last
            assign dn_rdy = bus.out_ready;
        end else begin : g_mid
            assign dn_rdy = g_stage[i+1].rdy;
        end

        clk_logic_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .in_vld_i  (up_vld),
            .in_dat_i  (up_dat),
            .in_rdy_o  (rdy),
            .out_vld_o (vld),
            .out_dat_o (dat),
            .out_rdy_i (dn_rdy)
        );
    end

    assign in_rdy        = !reset && g_stage[0].rdy;
    assign accept        = bus.in_valid && in_rdy;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = g_stage[STAGES-1].vld;
    assign bus.y         = g_stage[STAGES-1].dat;

    // Op decode and accumulator next state: a clear in the same cycle as an
    // accumulating beat is applied first, so that beat starts from zero.
    always_comb begin
        acc_base = bus.acc_clr ? '0 : acc_q;
        res      = WIDTH'(apply_op(bus.op, 32'(bus.a), 32'(bus.b), 32'(acc_base)));
        acc_d    = acc_base;
        if (accept && is_acc_op(bus.op)) begin
            acc_d = res;
        end
    end

    // Accumulator register; only accepted ACC_* beats or acc_clr change it.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: tb/tb_clk_logic_pipe.sv
// Directed bench for clk_logic_pipe at STAGES=2, plus STAGES=1 and STAGES=4 streams.
// Expected results are hand-computed or come from a small bench-side op model.
// Outputs are sampled 1 time unit after the rising edge, inputs driven there too.
module tb_clk_logic_pipe;
    import clk_logic_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    clk_logic_pipe_if #(.WIDTH(W)) if0 ();
    clk_logic_pipe_if #(.WIDTH(W)) if1 ();
    clk_logic_pipe_if #(.WIDTH(W)) if2 ();

    clk_logic_pipe #(.WIDTH(W), .STAGES(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    clk_logic_pipe #(.WIDTH(W), .STAGES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    clk_logic_pipe #(.WIDTH(W), .STAGES(4)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    // Per-DUT drive/observe arrays: index 0 = STAGES 2, 1 = STAGES 1, 2 = STAGES 4.
    logic         s_in_valid [3];
    op_t          s_op       [3];
    logic [W-1:0] s_a        [3];
    logic [W-1:0] s_b        [3];
    logic         s_clr      [3];
    logic         s_out_ready[3];
    logic         s_in_ready [3];
    logic         s_out_valid[3];
    logic [W-1:0] s_y        [3];

    assign if0.in_valid = s_in_valid[0]; assign if0.op = s_op[0]; assign if0.a = s_a[0];
    assign if0.b = s_b[0]; assign if0.acc_clr = s_clr[0]; assign if0.out_ready = s_out_ready[0];
    assign if1.in_valid = s_in_valid[1]; assign if1.op = s_op[1]; assign if1.a = s_a[1];
    assign if1.b = s_b[1]; assign if1.acc_clr = s_clr[1]; assign if1.out_ready = s_out_ready[1];
    assign if2.in_valid = s_in_valid[2]; assign if2.op = s_op[2]; assign if2.a = s_a[2];
    assign if2.b = s_b[2]; assign if2.acc_clr = s_clr[2]; assign if2.out_ready = s_out_ready[2];
    assign s_in_ready[0] = if0.in_ready; assign s_out_valid[0] = if0.out_valid; assign s_y[0] = if0.y;
    assign s_in_ready[1] = if1.in_ready; assign s_out_valid[1] = if1.out_valid; assign s_y[1] = if1.y;
    assign s_in_ready[2] = if2.in_ready; assign s_out_valid[2] = if2.out_valid; assign s_y[2] = if2.y;

    int n_checks = 0;
    int n_fail   = 0;

    // Beat list offered by run_stream and what it observed.
    op_t          q_op [$];
    logic [W-1:0] q_a  [$];
    logic [W-1:0] q_b  [$];
    logic         q_clr[$];
    logic [W-1:0] q_exp[$];
    int           acc_cyc[$];
    int           got_cyc[$];
    logic [W-1:0] got_y[$];

    task automatic clear_stream();
        q_op.delete(); q_a.delete(); q_b.delete(); q_clr.delete(); q_exp.delete();
        acc_cyc.delete(); got_cyc.delete(); got_y.delete();
    endtask

    task automatic add_beat(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic clr, input logic [W-1:0] exp);
        q_op.push_back(op); q_a.push_back(a); q_b.push_back(b);
        q_clr.push_back(clr); q_exp.push_back(exp);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offers the queued beats in order for ncyc cycles, recording acceptance
    // and output cycles. Called and returns at posedge+1.
    task automatic run_stream(input int idx, input int ncyc, input bit rnd);
        int ptr;
        ptr = 0;
        for (int c = 0; c < ncyc; c++) begin
            logic         v, ir, ov, orr;
            logic [W-1:0] yv;
            v = (ptr < q_op.size());
            s_in_valid[idx] = v;
            if (v) begin
                s_op[idx] = q_op[ptr]; s_a[idx] = q_a[ptr];
                s_b[idx]  = q_b[ptr];  s_clr[idx] = q_clr[ptr];
            end else begin
                s_clr[idx] = 1'b0;
            end
            s_out_ready[idx] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            ir = s_in_ready[idx]; ov = s_out_valid[idx]; yv = s_y[idx]; orr = s_out_ready[idx];
            @(posedge clk);
            if (ov && orr) begin
                got_y.push_back(yv);
                got_cyc.push_back(c);
            end
            if (v && ir) begin
                acc_cyc.push_back(c);
                ptr++;
            end
            #1;
        end
        s_in_valid[idx]  = 1'b0;
        s_clr[idx]       = 1'b0;
        s_out_ready[idx] = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (s_out_valid[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, s_out_valid[i]);
            end
            n_checks++;
            if (s_y[i] !== 8'h00) begin
                n_fail++; $display("FAIL reset_y[%0d]: got %h expected 00", i, s_y[i]);
            end
        end
        n_checks++;
        if (s_in_ready[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0", s_in_ready[0]);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (s_in_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL release_in_ready: got %b expected 1", s_in_ready[0]);
        end
        sync();
    endtask

    task automatic test_basic();
        clear_stream();
        add_beat(OP_AND,  8'hF0, 8'h3C, 1'b0, 8'h30);
        add_beat(OP_NAND, 8'hFF, 8'hFF, 1'b0, 8'h00);
        run_stream(0, 8, 1'b0);
        n_checks++;
        if (got_y.size() != 2 || acc_cyc.size() != 2) begin
            n_fail++; $display("FAIL basic_count: got %0d outputs %0d accepts expected 2 2", got_y.size(), acc_cyc.size());
        end
        for (int k = 0; k < got_y.size() && k < 2; k++) begin
            n_checks++;
            if (got_y[k] !== q_exp[k]) begin
                n_fail++; $display("FAIL basic_y[%0d]: got %h expected %h", k, got_y[k], q_exp[k]);
            end
            n_checks++;
            if (k < acc_cyc.size() && got_cyc[k] - acc_cyc[k] != 2) begin
                n_fail++; $display("FAIL basic_latency[%0d]: got %0d expected 2", k, got_cyc[k] - acc_cyc[k]);
            end
        end
        n_checks++;
        if (acc_cyc.size() == 2 && acc_cyc[1] - acc_cyc[0] != 1) begin
            n_fail++; $display("FAIL basic_back_to_back: accept gap %0d expected 1", acc_cyc[1] - acc_cyc[0]);
        end
    endtask

    task automatic test_accum();
        clear_stream();
        add_beat(OP_ACC_XOR, 8'h0F, 8'hFF, 1'b1, 8'h0F);
        add_beat(OP_ACC_XOR, 8'hFF, 8'hFF, 1'b0, 8'hF0);
        add_beat(OP_ACC_OR,  8'h00, 8'h00, 1'b0, 8'hF0);
        run_stream(0, 8, 1'b0);
        n_checks++;
        if (got_y.size() != 3) begin
            n_fail++; $display("FAIL accum_count: got %0d expected 3", got_y.size());
        end
        for (int k = 0; k < got_y.size() && k < 3; k++) begin
            n_checks++;
            if (got_y[k] !== q_exp[k]) begin
                n_fail++; $display("FAIL accum_y[%0d]: got %h expected %h", k, got_y[k], q_exp[k]);
            end
        end
    endtask

    task automatic test_clear_collision();
        clear_stream();
        add_beat(OP_ACC_XOR, 8'h7E, 8'hFF, 1'b1, 8'h7E);
        add_beat(OP_ACC_OR,  8'h81, 8'h81, 1'b1, 8'h81);
        add_beat(OP_ACC_OR,  8'h00, 8'h00, 1'b0, 8'h81);
        run_stream(0, 8, 1'b0);
        n_checks++;
        if (got_y.size() != 3) begin
            n_fail++; $display("FAIL clear_count: got %0d expected 3", got_y.size());
        end
        for (int k = 0; k < got_y.size() && k < 3; k++) begin
            n_checks++;
            if (got_y[k] !== q_exp[k]) begin
                n_fail++; $display("FAIL clear_y[%0d]: got %h expected %h", k, got_y[k], q_exp[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] vals [3];
        int ptr;
        logic ir;
        vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h04;
        ptr = 0;
        s_out_ready[0] = 1'b0;
        s_op[0] = OP_XOR; s_b[0] = 8'h00; s_clr[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            s_in_valid[0] = (ptr < 3);
            if (ptr < 3) s_a[0] = vals[ptr];
            #1;
            ir = s_in_ready[0];
            @(posedge clk);
            if (s_in_valid[0] && ir) ptr++;
            #1;
        end
        n_checks++;
        if (ptr != 2) begin
            n_fail++; $display("FAIL bp_accepted: got %0d expected 2", ptr);
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (s_in_ready[0] !== 1'b0 || s_out_valid[0] !== 1'b1 || s_y[0] !== 8'h01) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got in_ready=%b out_valid=%b y=%h expected 0 1 01",
                         c, s_in_ready[0], s_out_valid[0], s_y[0]);
            end
            sync();
        end
        s_in_valid[0] = 1'b0;
        clear_stream();
        add_beat(OP_XOR, 8'h04, 8'h00, 1'b0, 8'h04);
        run_stream(0, 8, 1'b0);
        n_checks++;
        if (got_y.size() != 3) begin
            n_fail++; $display("FAIL bp_drain_count: got %0d expected 3", got_y.size());
        end
        for (int k = 0; k < got_y.size() && k < 3; k++) begin
            n_checks++;
            if (got_y[k] !== vals[k]) begin
                n_fail++; $display("FAIL bp_drain_y[%0d]: got %h expected %h", k, got_y[k], vals[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        s_out_ready[0] = 1'b0;
        s_clr[0] = 1'b1; s_op[0] = OP_ACC_XOR; s_a[0] = 8'h55; s_b[0] = 8'hFF;
        s_in_valid[0] = 1'b1;
        sync();
        s_clr[0] = 1'b0; s_op[0] = OP_AND; s_a[0] = 8'hFF; s_b[0] = 8'h0F;
        sync();
        reset = 1'b1;
        s_op[0] = OP_ACC_OR; s_a[0] = 8'hAA; s_b[0] = 8'hFF;
        #1;
        n_checks++;
        if (s_in_ready[0] !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 0", s_in_ready[0]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        s_in_valid[0] = 1'b0;
        n_checks++;
        if (s_out_valid[0] !== 1'b0 || s_y[0] !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_out: got out_valid=%b y=%h expected 0 00", s_out_valid[0], s_y[0]);
        end
        clear_stream();
        add_beat(OP_ACC_OR, 8'h01, 8'hFF, 1'b0, 8'h01);
        run_stream(0, 6, 1'b0);
        n_checks++;
        if (got_y.size() != 1) begin
            n_fail++; $display("FAIL rst_mid_count: got %0d expected 1", got_y.size());
        end else begin
            n_checks++;
            if (got_y[0] !== 8'h01) begin
                n_fail++; $display("FAIL rst_mid_y: got %h expected 01", got_y[0]);
            end
        end
    endtask

    task automatic test_stream_depth(input int idx, input int stages, input string name);
        logic [W-1:0] m_acc, ra, rb, r;
        op_t          rop;
        logic         rc;
        clear_stream();
        m_acc = '0;
        for (int k = 0; k < 40; k++) begin
            rop = op_t'(3'($urandom_range(0, 7)));
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = ($urandom_range(0, 7) == 0);
            if (rc) m_acc = '0;
            case (rop)
                OP_AND:     r = ra & rb;
                OP_OR:      r = ra | rb;
                OP_XOR:     r = ra ^ rb;
                OP_NAND:    r = ~(ra & rb);
                OP_NOR:     r = ~(ra | rb);
                OP_XNOR:    r = ~(ra ^ rb);
                OP_ACC_XOR: begin m_acc = m_acc ^ (ra & rb); r = m_acc; end
                default:    begin m_acc = m_acc | (ra & rb); r = m_acc; end
            endcase
            add_beat(rop, ra, rb, rc, r);
        end
        run_stream(idx, 400, 1'b1);
        n_checks++;
        if (got_y.size() != 40) begin
            n_fail++; $display("FAIL %s_count: got %0d expected 40", name, got_y.size());
        end
        for (int k = 0; k < got_y.size() && k < 40; k++) begin
            n_checks++;
            if (got_y[k] !== q_exp[k]) begin
                n_fail++; $display("FAIL %s_y[%0d]: got %h expected %h", name, k, got_y[k], q_exp[k]);
            end
        end
        clear_stream();
        add_beat(OP_AND, 8'hC3, 8'h0F, 1'b0, 8'h03);
        add_beat(OP_AND, 8'hFF, 8'h80, 1'b0, 8'h80);
        add_beat(OP_OR,  8'h10, 8'h01, 1'b0, 8'h11);
        run_stream(idx, 12, 1'b0);
        n_checks++;
        if (got_y.size() != 3 || acc_cyc.size() != 3) begin
            n_fail++; $display("FAIL %s_lat_count: got %0d outputs expected 3", name, got_y.size());
        end
        for (int k = 0; k < got_y.size() && k < acc_cyc.size() && k < 3; k++) begin
            n_checks++;
            if (got_y[k] !== q_exp[k] || got_cyc[k] - acc_cyc[k] != stages) begin
                n_fail++;
                $display("FAIL %s_latency[%0d]: got y=%h lat=%0d expected y=%h lat=%0d",
                         name, k, got_y[k], got_cyc[k] - acc_cyc[k], q_exp[k], stages);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_in_valid[i] = 1'b0; s_op[i] = OP_AND; s_a[i] = '0; s_b[i] = '0;
            s_clr[i] = 1'b0; s_out_ready[i] = 1'b1;
        end
        test_reset();
        test_basic();
        test_accum();
        test_clear_collision();
        test_backpressure();
        test_reset_mid();
        test_stream_depth(1, 1, "depth1");
        test_stream_depth(2, 4, "depth4");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule
